// File: rtl/uart_receiver_fsm.sv
// -----------------------------------------------------------------------------
// uart_receiver_fsm
//
// UART receive state machine for 8N1 frames (1 start bit, 8 data bits sent
// LSB first, 1 stop bit, no parity). The bit clock comes from a fixed divider
// of CLKS_PER_BIT system clocks per serial bit. Each bit is sampled at its
// middle.
//
// Parameters:
//   CLKS_PER_BIT : system clocks per serial bit (N). Must be >= 2.
//
// Ports:
//   clk       : system clock. All state changes on the rising edge.
//   rst       : asynchronous reset, active low.
//   rx        : serial line. Idle level is high. Asynchronous to clk.
//   dout      : the last byte that was framed correctly. Holds between frames.
//   valid     : one-cycle strobe. dout changes in the same cycle.
//   frame_err : one-cycle strobe. The stop bit was sampled low.
//   busy      : high while a frame is being received.
// -----------------------------------------------------------------------------
module uart_receiver_fsm #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Synchronizer chain. rx_d_q holds the previous rx_s_q value so that
    // falling edges can be detected.
    logic sync1_q;
    logic rx_s_q;
    logic rx_d_q;

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;
    logic [7:0]       dout_q,    dout_d;
    logic             valid_q,   valid_d;
    logic             ferr_q,    ferr_d;
    logic             busy_q,    busy_d;

    // Reset forces the synchronizer to all ones. Those are not real samples
    // of the line. If rx is still low when reset is released, the chain
    // would show a false falling edge. fill_q counts the clocks until the
    // chain holds genuine samples. armed_q is then set the first time the
    // line is really seen high. Only after that is a start edge accepted.
    logic [1:0] fill_q,  fill_d;
    logic       armed_q, armed_d;

    logic cnt_last;
    logic cnt_mid;
    logic start_edge;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            rx_d_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            rx_s_q  <= sync1_q;
            rx_d_q  <= rx_s_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
            fill_q    <= '0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
            fill_q    <= fill_d;
            armed_q   <= armed_d;
        end
    end

    assign cnt_last   = (cnt_q == CNT_LAST);
    assign cnt_mid    = (cnt_q == CNT_MID);
    assign start_edge = armed_q && rx_d_q && !rx_s_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        dout_d    = dout_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        fill_d    = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
        armed_d   = armed_q || ((fill_q == 2'd2) && rx_s_q);

        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end

            S_START: begin
                if (cnt_mid) begin
                    if (!rx_s_q) begin
                        state_d   = S_DATA;
                        cnt_d     = '0;
                        bit_idx_d = '0;
                    end else begin
                        // The line is back high at mid start bit, so the
                        // edge was a glitch. Drop it without a pulse.
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DATA: begin
                if (cnt_last) begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    cnt_d     = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_STOP: begin
                if (cnt_last) begin
                    if (rx_s_q) begin
                        dout_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    // IDLE starts here, half a bit before the end of the
                    // stop bit. A start edge that follows right away is
                    // still caught.
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // busy stays high through the result-strobe cycle. It is not
        // extended when a glitch is rejected.
        busy_d = (state_d != S_IDLE) || valid_d || ferr_d;
    end

    assign dout      = dout_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_receiver_fsm.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver_fsm
//
// Drives three receivers in parallel, with N = 4, 16 and 5. A task that
// sends a frame also pushes the expected result (byte, error flag and strobe
// cycle) into that lane's queue. A negedge monitor pops the queue and
// compares each time a receiver strobes valid or frame_err.
// -----------------------------------------------------------------------------
module tb_uart_receiver_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       rx4, rx16, rx5;
    logic [7:0] dout4, dout16, dout5;
    logic       valid4, valid16, valid5;
    logic       ferr4, ferr16, ferr5;
    logic       busy4, busy16, busy5;

    uart_receiver_fsm #(.CLKS_PER_BIT(4)) u_dut4 (
        .clk(clk), .rst(rst), .rx(rx4), .dout(dout4),
        .valid(valid4), .frame_err(ferr4), .busy(busy4)
    );
    uart_receiver_fsm #(.CLKS_PER_BIT(16)) u_dut16 (
        .clk(clk), .rst(rst), .rx(rx16), .dout(dout16),
        .valid(valid16), .frame_err(ferr16), .busy(busy16)
    );
    uart_receiver_fsm #(.CLKS_PER_BIT(5)) u_dut5 (
        .clk(clk), .rst(rst), .rx(rx5), .dout(dout5),
        .valid(valid5), .frame_err(ferr5), .busy(busy5)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
        int         at;
    } exp_t;

    exp_t sb4[$];
    exp_t sb16[$];
    exp_t sb5[$];

    function automatic int lane_n(input int lane);
        if (lane == 0) return 4;
        if (lane == 1) return 16;
        return 5;
    endfunction

    function automatic int sb_size(input int lane);
        if (lane == 0) return sb4.size();
        if (lane == 1) return sb16.size();
        return sb5.size();
    endfunction

    function automatic exp_t sb_pop(input int lane);
        if (lane == 0) return sb4.pop_front();
        if (lane == 1) return sb16.pop_front();
        return sb5.pop_front();
    endfunction

    task automatic sb_push(input int lane, input exp_t e);
        if (lane == 0) sb4.push_back(e);
        else if (lane == 1) sb16.push_back(e);
        else sb5.push_back(e);
    endtask

    task automatic sb_clear(input int lane);
        if (lane == 0) sb4.delete();
        else if (lane == 1) sb16.delete();
        else sb5.delete();
    endtask

    task automatic set_rx(input int lane, input logic v);
        if (lane == 0) rx4 = v;
        else if (lane == 1) rx16 = v;
        else rx5 = v;
    endtask

    // Every driving step leaves the bench 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends one 8N1 frame. The line is left at stop_val when the task
    // returns. The raw line falls in cycle k. The second synchronizer stage
    // sees it at t0 = k+2, and the strobe is due at t0 + N/2 + 9N + 1.
    task automatic send_frame(input int lane, input logic [7:0] data,
                              input logic stop_val, input logic [7:0] hold_dout);
        int   n;
        int   k;
        exp_t e;
        n      = lane_n(lane);
        k      = cyc;
        e.data = stop_val ? data : hold_dout;
        e.err  = ~stop_val;
        e.at   = k + 2 + n / 2 + 9 * n + 1;
        sb_push(lane, e);
        set_rx(lane, 1'b0);
        tick(n);
        for (int i = 0; i < 8; i++) begin
            set_rx(lane, data[i]);
            tick(n);
        end
        set_rx(lane, stop_val);
        tick(n);
    endtask

    task automatic wait_drain(input int lane, input int budget);
        int i;
        i = 0;
        while (sb_size(lane) != 0 && i < budget) begin
            tick(1);
            i++;
        end
        tests_run++;
        if (sb_size(lane) != 0) begin
            tests_failed++;
            $display("[TB] FAIL drain lane%0d: %0d results still pending after %0d cycles, required 0",
                     lane, sb_size(lane), budget);
            sb_clear(lane);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic       v;
        logic       e;
        logic [7:0] d;
        exp_t       got;
        for (int l = 0; l < 3; l++) begin
            if (l == 0) begin v = valid4;  e = ferr4;  d = dout4;  end
            else if (l == 1) begin v = valid16; e = ferr16; d = dout16; end
            else begin v = valid5;  e = ferr5;  d = dout5;  end
            if (v === 1'b1 || e === 1'b1) begin
                tests_run++;
                if (v === 1'b1 && e === 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL exclusive lane%0d: valid=%b frame_err=%b, required not both high",
                             l, v, e);
                end
                tests_run++;
                if (sb_size(l) == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL unexpected lane%0d cycle %0d: valid=%b frame_err=%b dout=%h, required no strobe",
                             l, cyc, v, e, d);
                end else begin
                    got = sb_pop(l);
                    if (e !== got.err || v !== ~got.err || d !== got.data || cyc != got.at) begin
                        tests_failed++;
                        $display("[TB] FAIL frame lane%0d: got dout=%h err=%b at %0d, required dout=%h err=%b at %0d",
                                 l, d, e, cyc, got.data, got.err, got.at);
                    end else begin
                        $display("[TB] lane%0d frame dout=%h err=%b at cycle %0d ok", l, d, e, cyc);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        logic [10:0] o;
        rst  = 1'b0;
        rx4  = 1'b1;
        rx16 = 1'b1;
        rx5  = 1'b1;
        tick(3);
        for (int l = 0; l < 3; l++) begin
            if (l == 0) o = {dout4, valid4, ferr4, busy4};
            else if (l == 1) o = {dout16, valid16, ferr16, busy16};
            else o = {dout5, valid5, ferr5, busy5};
            tests_run++;
            if (o !== 11'h000) begin
                tests_failed++;
                $display("[TB] FAIL reset lane%0d: {dout,valid,ferr,busy}=%h, required 000", l, o);
            end
        end
        rst = 1'b1;
        tick(6);
        tests_run++;
        if ({busy4, busy16, busy5} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL idle_busy: busy=%b, required 000", {busy4, busy16, busy5});
        end
    endtask

    task automatic test_single_byte();
        send_frame(0, 8'hA5, 1'b1, 8'h00);
        wait_drain(0, 20);
        tick(2);
        tests_run++;
        if (dout4 !== 8'hA5 || busy4 !== 1'b0 || ferr4 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_byte: dout=%h busy=%b ferr=%b, required A5 0 0", dout4, busy4, ferr4);
        end
    endtask

    task automatic test_framing_error();
        send_frame(0, 8'h3C, 1'b0, 8'hA5);
        tick(4);                     // stop bit held low for 8 cycles total
        wait_drain(0, 10);
        tests_run++;
        if (busy4 !== 1'b0 || dout4 !== 8'hA5) begin
            tests_failed++;
            $display("[TB] FAIL frame_err_hold: busy=%b dout=%h, required 0 A5", busy4, dout4);
        end
        tick(6);                     // line still low: must not start a frame
        tests_run++;
        if (busy4 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL level_low_start: busy=%b, required 0", busy4);
        end
        set_rx(0, 1'b1);
        tick(8);
        send_frame(0, 8'h5A, 1'b1, 8'hA5);
        wait_drain(0, 20);
        tests_run++;
        if (dout4 !== 8'h5A) begin
            tests_failed++;
            $display("[TB] FAIL recover_after_err: dout=%h, required 5A", dout4);
        end
    endtask

    task automatic test_glitch();
        int busy_cnt;
        busy_cnt = 0;
        tick(4);
        set_rx(1, 1'b0);
        tick(1);
        set_rx(1, 1'b1);
        for (int i = 0; i < 30; i++) begin
            if (busy16 === 1'b1) busy_cnt++;
            tick(1);
        end
        tests_run++;
        if (busy_cnt != 8) begin
            tests_failed++;
            $display("[TB] FAIL glitch_busy: busy high %0d cycles, required 8", busy_cnt);
        end
        tests_run++;
        if (sb_size(1) != 0 || valid16 !== 1'b0 || ferr16 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL glitch_quiet: pending=%0d valid=%b ferr=%b, required 0 0 0",
                     sb_size(1), valid16, ferr16);
        end
    endtask

    task automatic test_back_to_back();
        tick(16);
        send_frame(1, 8'h00, 1'b1, 8'h00);
        send_frame(1, 8'hFF, 1'b1, 8'h00);
        send_frame(1, 8'h55, 1'b1, 8'hFF);
        wait_drain(1, 40);
        tests_run++;
        if (dout16 !== 8'h55) begin
            tests_failed++;
            $display("[TB] FAIL back_to_back_last: dout=%h, required 55", dout16);
        end
    endtask

    task automatic test_reset_mid_frame();
        int busy_cnt;
        logic [7:0] b;
        b = 8'h81;
        busy_cnt = 0;
        tick(16);
        set_rx(1, 1'b0);             // start bit
        tick(16);
        for (int i = 0; i < 3; i++) begin
            set_rx(1, b[i]);
            tick(16);
        end
        set_rx(1, b[3]);             // data bit 3 (low)
        tick(8);
        tests_run++;
        if (busy16 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL mid_frame_busy: busy=%b, required 1", busy16);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if ({dout16, valid16, ferr16, busy16} !== 11'h000) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: {dout,valid,ferr,busy}=%h, required 000",
                     {dout16, valid16, ferr16, busy16});
        end
        tick(3);
        rst = 1'b1;                  // rx16 still low here
        for (int i = 0; i < 40; i++) begin
            if (busy16 === 1'b1) busy_cnt++;
            tick(1);
        end
        tests_run++;
        if (busy_cnt != 0) begin
            tests_failed++;
            $display("[TB] FAIL release_low: busy high %0d cycles, required 0", busy_cnt);
        end
        set_rx(1, 1'b1);
        tick(20);
        send_frame(1, 8'h42, 1'b1, 8'h00);
        wait_drain(1, 40);
        tests_run++;
        if (dout16 !== 8'h42) begin
            tests_failed++;
            $display("[TB] FAIL after_reset_frame: dout=%h, required 42", dout16);
        end
    endtask

    task automatic test_odd_divider();
        tick(5);
        send_frame(2, 8'hC3, 1'b1, 8'h00);
        wait_drain(2, 20);
        tests_run++;
        if (dout5 !== 8'hC3) begin
            tests_failed++;
            $display("[TB] FAIL odd_divider: dout=%h, required C3", dout5);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_framing_error();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        test_odd_divider();
        tick(10);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
